// File: rtl/mem_port_arbiter_if.sv
// Memory-port bundle between the arbiter (master) and the memory (slave).
interface mem_port_arbiter_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wmask,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, with a
// starvation guard favouring IF and a bounded wait that aborts stuck accesses.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               if_req,
    input  logic [31:0]        if_addr,
    output logic               if_ack,
    output logic [31:0]        if_rdata,
    input  logic               ls_req,
    input  logic               ls_we,
    input  logic [31:0]        ls_addr,
    input  logic [31:0]        ls_wdata,
    input  logic [3:0]         ls_wmask,
    output logic               ls_ack,
    output logic [31:0]        ls_rdata,
    output logic               bus_err,
    output logic               port_sel,
    mem_port_arbiter_if.master mem
);

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WAIT_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_LS = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  streak_q, streak_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        port_sel_q, port_sel_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_wmask_q, mem_wmask_d;
    logic        if_ack_q, if_ack_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        ls_ack_q, ls_ack_d;
    logic [31:0] ls_rdata_q, ls_rdata_d;
    logic        bus_err_q, bus_err_d;
    logic        abort;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            wait_cnt_q  <= '0;
            port_sel_q  <= 1'b0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            if_ack_q    <= 1'b0;
            if_rdata_q  <= '0;
            ls_ack_q    <= 1'b0;
            ls_rdata_q  <= '0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            wait_cnt_q  <= wait_cnt_d;
            port_sel_q  <= port_sel_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            if_ack_q    <= if_ack_d;
            if_rdata_q  <= if_rdata_d;
            ls_ack_q    <= ls_ack_d;
            ls_rdata_q  <= ls_rdata_d;
            bus_err_q   <= bus_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        wait_cnt_d  = wait_cnt_q;
        port_sel_d  = port_sel_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        if_ack_d    = 1'b0;
        if_rdata_d  = '0;
        ls_ack_d    = 1'b0;
        ls_rdata_d  = '0;
        bus_err_d   = 1'b0;
        abort       = !mem.mem_ready && (wait_cnt_q == WAIT_LAST);

        case (state_q)
            // The ack cycle is a recovery cycle so a finished requester can drop req.
            IDLE: begin
                if (!if_ack_q && !ls_ack_q) begin
                    if (if_req && (!ls_req || streak_q == STREAK_MAX)) begin
                        state_d     = BUSY_IF;
                        streak_d    = '0;
                        wait_cnt_d  = '0;
                        port_sel_d  = 1'b0;
                        mem_req_d   = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_wmask_d = '0;
                    end else if (ls_req) begin
                        state_d     = BUSY_LS;
                        wait_cnt_d  = '0;
                        port_sel_d  = 1'b1;
                        mem_req_d   = 1'b1;
                        mem_we_d    = ls_we;
                        mem_addr_d  = ls_addr;
                        mem_wdata_d = ls_wdata;
                        mem_wmask_d = ls_we ? ls_wmask : 4'h0;
                        if (if_req && streak_q < STREAK_MAX) begin
                            streak_d = streak_q + 4'd1;
                        end
                    end
                end
            end
            // A timed-out access acks with zero data and flags bus_err.
            BUSY_IF, BUSY_LS: begin
                if (mem.mem_ready || abort) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                    bus_err_d = abort;
                    if (state_q == BUSY_IF) begin
                        if_ack_d   = 1'b1;
                        if_rdata_d = mem.mem_ready ? mem.mem_rdata : 32'h0;
                    end else begin
                        ls_ack_d   = 1'b1;
                        ls_rdata_d = (mem.mem_ready && !mem_we_q) ? mem.mem_rdata : 32'h0;
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign if_ack        = if_ack_q;
    assign if_rdata      = if_rdata_q;
    assign ls_ack        = ls_ack_q;
    assign ls_rdata      = ls_rdata_q;
    assign bus_err       = bus_err_q;
    assign port_sel      = port_sel_q;
    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: latency, store/load payloads, starvation
// rotation, timeout abort, ack recovery cycle and mid-access reset.
module tb_mem_port_arbiter;

    logic        clk;
    logic        reset;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_wmask;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        bus_err;
    logic        port_sel;
    logic        auto_ready;
    logic [31:0] rdata_val;

    int tests_run;
    int tests_failed;

    mem_port_arbiter_if bus();

    // The memory answers in the first busy cycle whenever auto_ready is set.
    assign bus.mem_ready = auto_ready & bus.mem_req;
    assign bus.mem_rdata = rdata_val;

    mem_port_arbiter #(.STARVE_LIMIT(4), .TIMEOUT(16)) dut (
        .clk      (clk),
        .reset    (reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_we    (ls_we),
        .ls_addr  (ls_addr),
        .ls_wdata (ls_wdata),
        .ls_wmask (ls_wmask),
        .ls_ack   (ls_ack),
        .ls_rdata (ls_rdata),
        .bus_err  (bus_err),
        .port_sel (port_sel),
        .mem      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic ifr, input logic [31:0] ifa,
                                 input logic lsr, input logic lswe, input logic [31:0] lsa,
                                 input logic [31:0] lsd, input logic [3:0] lsm);
        if_req   = ifr;
        if_addr  = ifa;
        ls_req   = lsr;
        ls_we    = lswe;
        ls_addr  = lsa;
        ls_wdata = lsd;
        ls_wmask = lsm;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_flags"}, {26'h0, if_ack, ls_ack, bus_err, port_sel, bus.mem_req, bus.mem_we}, 32'h0);
        checkOutput({tag, "_addr"}, bus.mem_addr, 32'h0);
        checkOutput({tag, "_wdata"}, bus.mem_wdata, 32'h0);
        checkOutput({tag, "_wmask"}, {28'h0, bus.mem_wmask}, 32'h0);
        checkOutput({tag, "_if_rdata"}, if_rdata, 32'h0);
        checkOutput({tag, "_ls_rdata"}, ls_rdata, 32'h0);
    endtask

    initial begin
        logic [7:0] grant_bits;
        int         grant_cnt;
        logic       prev_req;
        int         wait_steps;

        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b0;
        auto_ready   = 1'b1;
        rdata_val    = 32'hDEADBEEF;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        tick();
        checkAllZero("reset");
        reset = 1'b1;
        tick();

        // IF alone
        applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("if_grant_req", {31'h0, bus.mem_req}, 32'h1);
        checkOutput("if_grant_addr", bus.mem_addr, 32'h100);
        checkOutput("if_grant_we", {31'h0, bus.mem_we}, 32'h0);
        checkOutput("if_grant_sel", {31'h0, port_sel}, 32'h0);
        checkOutput("if_no_early_ack", {31'h0, if_ack}, 32'h0);
        tick();
        checkOutput("if_ack", {31'h0, if_ack}, 32'h1);
        checkOutput("if_rdata", if_rdata, 32'hDEADBEEF);
        checkOutput("if_req_drop", {31'h0, bus.mem_req}, 32'h0);
        if_req = 1'b0;
        tick();
        checkOutput("if_ack_pulse", {31'h0, if_ack}, 32'h0);
        checkOutput("if_rdata_clr", if_rdata, 32'h0);

        // Store
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h2000, 32'h12345678, 4'h3);
        tick();
        checkOutput("st_req", {31'h0, bus.mem_req}, 32'h1);
        checkOutput("st_we", {31'h0, bus.mem_we}, 32'h1);
        checkOutput("st_addr", bus.mem_addr, 32'h2000);
        checkOutput("st_wdata", bus.mem_wdata, 32'h12345678);
        checkOutput("st_wmask", {28'h0, bus.mem_wmask}, 32'h3);
        checkOutput("st_sel", {31'h0, port_sel}, 32'h1);
        tick();
        checkOutput("st_ack", {31'h0, ls_ack}, 32'h1);
        checkOutput("st_rdata", ls_rdata, 32'h0);
        ls_req = 1'b0;
        tick();
        checkOutput("st_sel_hold", {31'h0, port_sel}, 32'h1);

        // Load
        rdata_val = 32'hCAFEF00D;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h3000, 32'hFFFF0000, 4'hF);
        tick();
        checkOutput("ld_wmask", {28'h0, bus.mem_wmask}, 32'h0);
        checkOutput("ld_we", {31'h0, bus.mem_we}, 32'h0);
        tick();
        checkOutput("ld_ack", {31'h0, ls_ack}, 32'h1);
        checkOutput("ld_rdata", ls_rdata, 32'hCAFEF00D);
        ls_req = 1'b0;
        tick();

        // Contention: expect LS,LS,LS,LS,IF,LS,LS
        grant_bits = '0;
        grant_cnt  = 0;
        prev_req   = bus.mem_req;
        applyStimulus(1'b1, 32'h400, 1'b1, 1'b0, 32'h4000, 32'h0, 4'h0);
        for (int i = 0; i < 21; i++) begin
            tick();
            if (bus.mem_req && !prev_req) begin
                grant_bits = {grant_bits[6:0], port_sel};
                grant_cnt++;
            end
            prev_req = bus.mem_req;
        end
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        checkOutput("cont_grant_cnt", grant_cnt, 32'd7);
        checkOutput("cont_order", {24'h0, grant_bits}, 32'h7B);
        tick();
        checkOutput("cont_settle", {31'h0, bus.mem_req}, 32'h0);

        // Timeout
        auto_ready = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        tick();
        checkOutput("to_grant", {31'h0, bus.mem_req}, 32'h1);
        wait_steps = 0;
        while (!ls_ack && wait_steps < 30) begin
            tick();
            wait_steps++;
        end
        checkOutput("to_latency", wait_steps, 32'd16);
        checkOutput("to_bus_err", {31'h0, bus_err}, 32'h1);
        checkOutput("to_rdata", ls_rdata, 32'h0);
        checkOutput("to_req_clr", {31'h0, bus.mem_req}, 32'h0);
        ls_req     = 1'b0;
        auto_ready = 1'b1;
        tick();
        checkOutput("to_err_pulse", {30'h0, bus_err, ls_ack}, 32'h0);

        // Back-to-back IF: no grant in the ack cycle
        rdata_val = 32'h11112222;
        applyStimulus(1'b1, 32'h300, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("b2b_grant1", {31'h0, bus.mem_req}, 32'h1);
        tick();
        checkOutput("b2b_ack1", {31'h0, if_ack}, 32'h1);
        checkOutput("b2b_rdata1", if_rdata, 32'h11112222);
        tick();
        checkOutput("b2b_recovery", {30'h0, bus.mem_req, if_ack}, 32'h0);
        tick();
        checkOutput("b2b_regrant", {31'h0, bus.mem_req}, 32'h1);
        checkOutput("b2b_addr", bus.mem_addr, 32'h300);
        tick();
        checkOutput("b2b_ack2", {31'h0, if_ack}, 32'h1);
        if_req = 1'b0;
        tick();

        // Reset mid-access
        auto_ready = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, 32'h5000, 32'h0BADF00D, 4'hF);
        tick();
        checkOutput("rst_busy_sel", {31'h0, port_sel}, 32'h1);
        reset = 1'b0;
        #1;
        checkAllZero("rst_mid");
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        reset = 1'b1;
        tick();
        checkOutput("rst_no_ack", {29'h0, ls_ack, bus_err, bus.mem_req}, 32'h0);
        auto_ready = 1'b1;
        rdata_val  = 32'hA5A5A5A5;
        applyStimulus(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        checkOutput("rst_if_addr", bus.mem_addr, 32'h500);
        checkOutput("rst_if_sel", {31'h0, port_sel}, 32'h0);
        tick();
        checkOutput("rst_if_ack", {31'h0, if_ack}, 32'h1);
        checkOutput("rst_if_rdata", if_rdata, 32'hA5A5A5A5);
        if_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Sequential arbiter that shares the core's single memory port between the instruction-fetch path (IF) and the load/store path (LS). It registers the winning request onto the port and owns the port-select line that steers the address and write-data multiplexers. It returns a one-cycle acknowledge with read data to the owner. A bounded wait timeout and a starvation guard keep both requesters making progress.

## Interface
- STARVE_LIMIT, 4: consecutive contended LS grants before IF is forced to win (1..15)
- TIMEOUT, 16: max cycles in a busy state without `mem_ready` before abort (2..255)
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset; one clock domain only
- if_req  input  1  IF request; held with `if_addr` until `if_ack`
- if_addr  input  32  IF word address
- if_ack  output  1  one-cycle completion pulse to IF
- if_rdata  output  32  fetched word, valid while `if_ack`=1
- ls_req  input  1  LS request; held with payload until `ls_ack`
- ls_we  input  1  1 = store, 0 = load
- ls_addr  input  32  LS address
- ls_wdata  input  32  store data
- ls_wmask  input  4  byte enables for store
- ls_ack  output  1  one-cycle completion pulse to LS
- ls_rdata  output  32  load word, valid while `ls_ack`=1
- bus_err  output  1  one-cycle pulse, coincident with the aborted requester's ack
- port_sel  output  1  owner select for the port muxes: 0 = IF, 1 = LS
- mem_req  output  1  port request, registered
- mem_we  output  1  registered write enable (0 for IF)
- mem_addr  output  32  registered address
- mem_wdata  output  32  registered write data (0 for IF)
- mem_wmask  output  4  registered byte mask (0 for IF or load)
- mem_ready  input  1  memory completes the current access this cycle
- mem_rdata  input  32  read data, valid with `mem_ready`

## Operation
- States: IDLE, BUSY_IF, BUSY_LS.
- IDLE: arbitration is enabled only when neither ack is high this cycle. This gives one recovery cycle so a requester can drop `req`.
  - Winner: LS if `ls_req` is high, except IF wins when `if_req` is high and `streak`==STARVE_LIMIT. IF wins if it requests alone.
  - On a grant: latch the winner's payload into `mem_*`, set `mem_req`=1, set `port_sel`, go to BUSY_x, clear `wait_cnt`.
- `streak` (4 bit):
  - +1 on an LS grant made while `if_req`=1.
  - Cleared on any IF grant.
  - Unchanged on an uncontended LS grant.
  - Saturates at STARVE_LIMIT.
- BUSY_x, `mem_ready`=1: at the next edge, x_ack=1, x_rdata=`mem_rdata` (0 for stores), `mem_req`=0, state returns to IDLE.
- BUSY_x, `mem_ready`=0: `wait_cnt`+1. When `wait_cnt`==TIMEOUT-1, at the next edge, x_ack=1, x_rdata=0, `bus_err`=1, `mem_req`=0, state returns to IDLE.
- `port_sel` holds its last value in IDLE and only changes on a grant.
- Requests that drop before their ack are a protocol violation. The current access still completes and acks.

## Timing
- Reset (async assert, sync release): state=IDLE; `streak`=0; `wait_cnt`=0; every output is 0, including `port_sel`, `mem_*`, acks, rdata and `bus_err`.
- Reset asserted mid-access aborts immediately with no ack and no `bus_err`.
- Latency: request sampled in IDLE at edge k; `mem_req` is high from k+1; `mem_ready` at k+1 gives ack at k+2. The minimum is 2 cycles.
- Ack, rdata and `bus_err` are high for exactly one cycle. The earliest next grant is one cycle after the ack cycle.
- `mem_*` stay stable for the entire busy state.
- `mem_ready` is ignored in IDLE.

## Test plan
- IF alone: `if_addr`=0x100, `mem_ready` one cycle after `mem_req`, `mem_rdata`=0xDEADBEEF → `mem_addr`=0x100, `mem_we`=0, `port_sel`=0; `if_ack` 2 cycles after request with `if_rdata`=0xDEADBEEF.
- Store: `ls_we`=1, `ls_addr`=0x2000, `ls_wdata`=0x12345678, `ls_wmask`=0x3 → `mem_*` carry those values and `port_sel`=1; `ls_ack` with `ls_rdata`=0.
- Contention with STARVE_LIMIT=4: both requests held continuously → grants go LS,LS,LS,LS,IF,LS… and `streak` resets after the IF grant.
- Timeout with TIMEOUT=16: `mem_ready` held at 0 → `ls_ack`=1 and `bus_err`=1 exactly 16 cycles after `mem_req` rises, then IDLE.
- Back-to-back: `if_req` still high in its ack cycle → no grant in that cycle; re-granted the cycle after.
- Reset mid-access: `reset`=0 during BUSY_LS → all outputs 0 immediately; after release, a new IF request is serviced normally.
